// File: rtl/if_pkg.sv
// Shared fetch-stage definitions: jump encoding, redirect priority and default vectors.
package if_pkg;

  // i_con_jump encoding; 11 is unused and means no jump
  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_J    = 2'b01,
    JMP_JR   = 2'b10,
    JMP_RSVD = 2'b11
  } jump_e;

  // Redirect priority, higher value wins
  typedef enum logic [2:0] {
    PRI_NONE = 3'd0,
    PRI_JR   = 3'd1,
    PRI_J    = 3'd2,
    PRI_BR   = 3'd3,
    PRI_EXC  = 3'd4
  } redir_pri_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

endpackage

// File: rtl/if_ras.sv
// Circular return-address stack: push overwrites oldest when full,
// push+pop together replaces the top in place.
module if_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign top   = empty ? '0 : mem[ptr];

  // Pointer and occupancy; a push while full wraps over the oldest entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push && !pop) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) cnt <= cnt + CNT_W'(1);
    end else if (pop && !push && !empty) begin
      ptr <= ptr - PTR_W'(1);
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Entry storage, unreset: occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (push && pop) mem[ptr] <= push_data;
    else if (push)   mem[ptr + PTR_W'(1)] <= push_data;
  end

endmodule

// File: rtl/if_pcgen.sv
// Fetch PC generator with prioritised redirects, stall-time pending redirect
// and optional return-address stack (enabled by macro IF_PCGEN_RAS_EN).
module if_pcgen
  import if_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              JADDR_W   = 26,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
  parameter int              RAS_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_exc,
  input  logic [JADDR_W-1:0] i_addr_jump,
  input  logic [ADDR_W-1:0]  i_addr_jumpr,
  input  logic [ADDR_W-1:0]  i_addr_branch,
  input  logic [1:0]         i_con_jump,
  input  logic               i_con_ifbranch,
  input  logic               i_con_link,
  input  logic               i_con_ret,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [ADDR_W-1:0]  o_pc_plus4,
  output logic               o_pend,
  output logic [ADDR_W-1:0]  o_ras_pred,
  output logic               o_ras_miss
);

  logic [ADDR_W-1:0] pc, pc_plus4, redir_tgt, pend_tgt;
  logic              redir_vld, pend_vld, pend_take;
  redir_pri_e        redir_pri, pend_pri;

  assign pc_plus4   = pc + ADDR_W'(4);
  assign o_pc       = pc;
  assign o_pc_plus4 = pc_plus4;
  assign o_pend     = pend_vld;

  // Resolve this cycle's redirect and whether a stall may (re)load pending
  always_comb begin
    redir_vld = 1'b1;
    redir_pri = PRI_NONE;
    redir_tgt = '0;
    if (i_exc) begin
      redir_pri = PRI_EXC;
      redir_tgt = EXC_VEC;
    end else if (i_con_ifbranch) begin
      redir_pri = PRI_BR;
      redir_tgt = i_addr_branch;
    end else if (i_con_jump == JMP_J) begin
      redir_pri = PRI_J;
      redir_tgt = {{(ADDR_W-JADDR_W){1'b0}}, i_addr_jump};
    end else if (i_con_jump == JMP_JR) begin
      redir_pri = PRI_JR;
      redir_tgt = i_addr_jumpr;
    end else begin
      redir_vld = 1'b0;
    end
    pend_take = i_stall && redir_vld && (!pend_vld || (redir_pri >= pend_pri));
  end

  // PC and pending-valid state: hold on stall, otherwise redirect > pending > +4
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc       <= RESET_VEC;
      pend_vld <= 1'b0;
      pend_pri <= PRI_NONE;
    end else if (i_stall) begin
      if (pend_take) begin
        pend_vld <= 1'b1;
        pend_pri <= redir_pri;
      end
    end else begin
      pend_vld <= 1'b0;
      pend_pri <= PRI_NONE;
      if (redir_vld)     pc <= redir_tgt;
      else if (pend_vld) pc <= pend_tgt;
      else               pc <= pc_plus4;
    end
  end

  // Pending target payload, qualified by pend_vld
  always_ff @(posedge i_clk) begin
    if (pend_take) pend_tgt <= redir_tgt;
  end

`ifdef IF_PCGEN_RAS_EN
  logic              ras_push, ras_pop, ras_empty, ras_full_unused, ras_miss;
  logic [ADDR_W-1:0] ras_top, ras_ret_addr;

  // Exceptions and stalls leave the stack untouched
  assign ras_push     = !i_stall && !i_exc && i_con_link;
  assign ras_pop      = !i_stall && !i_exc && i_con_ret;
  assign ras_ret_addr = pc_plus4 + ADDR_W'(4);

  if_ras #(
    .W     (ADDR_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (ras_ret_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full_unused)
  );

  // Miss flag: compare old top on pop, empty pop always misses, exception clears
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ras_miss <= 1'b0;
    end else if (!i_stall) begin
      if (i_exc)          ras_miss <= 1'b0;
      else if (i_con_ret) ras_miss <= ras_empty ? 1'b1 : (ras_top != i_addr_jumpr);
    end
  end

  assign o_ras_pred = ras_top;
  assign o_ras_miss = ras_miss;
`else
  logic unused_ras;
  assign unused_ras = ^{i_con_link, i_con_ret};
  assign o_ras_pred = '0;
  assign o_ras_miss = 1'b0;
`endif

endmodule

// File: tb/tb_if_pcgen.sv
// Self-checking bench for if_pcgen: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours IF_PCGEN_RAS_EN.
module tb_if_pcgen;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC   = 32'h0000_0080;
  localparam int          DEPTH     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, exc, cbr, link, ret;
  logic [25:0] aj;
  logic [31:0] ajr, abr;
  logic [1:0]  cj;
  logic [31:0] o_pc, o_pc_plus4, o_ras_pred;
  logic        o_pend, o_ras_miss;

  if_pcgen dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_stall        (stall),
    .i_exc          (exc),
    .i_addr_jump    (aj),
    .i_addr_jumpr   (ajr),
    .i_addr_branch  (abr),
    .i_con_jump     (cj),
    .i_con_ifbranch (cbr),
    .i_con_link     (link),
    .i_con_ret      (ret),
    .o_pc           (o_pc),
    .o_pc_plus4     (o_pc_plus4),
    .o_pend         (o_pend),
    .o_ras_pred     (o_ras_pred),
    .o_ras_miss     (o_ras_miss)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [31:0] m_pc, m_pt;
  bit          m_pv, m_miss;
  int          m_pp;
  logic [31:0] ras_q[$];
  logic [31:0] pushed[5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_pred();
    return (ras_q.size() != 0) ? ras_q[$] : 32'h0;
  endfunction

  task automatic model_reset();
    m_pc = RESET_VEC; m_pv = 0; m_pt = '0; m_pp = 0; m_miss = 0;
    ras_q.delete();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    o_pc,       m_pc);
    chk({tag, ".pc4"},   o_pc_plus4, m_pc + 32'd4);
    chk({tag, ".pend"},  {31'b0, o_pend},     {31'b0, m_pv});
    chk({tag, ".pred"},  o_ras_pred, m_pred());
    chk({tag, ".miss"},  {31'b0, o_ras_miss}, {31'b0, m_miss});
  endtask

  task automatic clr();
    stall = 0; exc = 0; cbr = 0; link = 0; ret = 0;
    aj = '0; ajr = '0; abr = '0; cj = 2'b00;
  endtask

  // Predict the next edge from the current inputs, advance one clock, compare
  task automatic cyc(input string tag);
    logic [31:0] tgt;
    int          pri;
    bit          rv;
    rv = 1; tgt = '0; pri = 0;
    if (exc)           begin tgt = EXC_VEC;       pri = 4; end
    else if (cbr)      begin tgt = abr;           pri = 3; end
    else if (cj == 1)  begin tgt = {6'b0, aj};    pri = 2; end
    else if (cj == 2)  begin tgt = ajr;           pri = 1; end
    else rv = 0;
    if (stall) begin
      if (rv && (!m_pv || pri >= m_pp)) begin
        m_pv = 1; m_pt = tgt; m_pp = pri;
      end
    end else begin
`ifdef IF_PCGEN_RAS_EN
      if (exc) m_miss = 0;
      else begin
        if (ret) m_miss = (ras_q.size() == 0) ? 1'b1 : (ras_q[$] != ajr);
        if (link && ret) begin
          if (ras_q.size() != 0) ras_q[ras_q.size()-1] = m_pc + 32'd8;
        end else if (link) begin
          ras_q.push_back(m_pc + 32'd8);
          if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
        end else if (ret && ras_q.size() != 0) begin
          void'(ras_q.pop_back());
        end
      end
`endif
      if (rv)        m_pc = tgt;
      else if (m_pv) m_pc = m_pt;
      else           m_pc = m_pc + 32'd4;
      m_pv = 0; m_pp = 0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic pulse_reset();
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("rst_mid");
    #2 rst_n = 1;
  endtask

  initial begin
    clr();
    // Reset state and first fetches
    #3;
    model_reset();
    check_all("rst");
    @(posedge clk);
    #1 rst_n = 1;
    chk("rel.pc", o_pc, 32'h0);
    cyc("seq1"); chk("seq.pc4", o_pc, 32'h4);
    cyc("seq2"); chk("seq.pc8", o_pc, 32'h8);
    cyc("seq3"); chk("seq.pcc", o_pc, 32'hc);

    // Branch beats jump
    cj = 2; ajr = 32'h100; cyc("jr100"); clr();
    chk("jr.pc", o_pc, 32'h100);
    cj = 1; aj = 26'h40; cbr = 1; abr = 32'h200; cyc("brj");
    clr(); chk("brj.pc", o_pc, 32'h200);

    // jr latched during stall, applied on first free edge
    stall = 1; cj = 2; ajr = 32'h300; cyc("stl1"); clr();
    chk("stl1.pend", {31'b0, o_pend}, 32'h1); chk("stl1.pc", o_pc, 32'h200);
    stall = 1; cyc("stl2"); clr();
    chk("stl2.pend", {31'b0, o_pend}, 32'h1); chk("stl2.pc", o_pc, 32'h200);
    cyc("stl3");
    chk("stl3.pc", o_pc, 32'h300); chk("stl3.pend", {31'b0, o_pend}, 32'h0);

    // Exception overrides a pending branch
    stall = 1; cbr = 1; abr = 32'h400; cyc("exc1"); clr();
    stall = 1; exc = 1; cyc("exc2"); clr();
    cyc("exc3");
    chk("exc.pc", o_pc, EXC_VEC);

    // Reset during stall drops the pending redirect
    stall = 1; cj = 2; ajr = 32'h500; cyc("rs1"); clr();
    pulse_reset();
    chk("rs.pc", o_pc, RESET_VEC);
    cyc("rs2");
    chk("rs2.pc", o_pc, RESET_VEC + 32'd4);

`ifdef IF_PCGEN_RAS_EN
    // Link/return pairing and empty pop
    cj = 2; ajr = 32'h10; cyc("r_j10"); clr();
    link = 1; cyc("r_jal"); clr();
    chk("ras.push", o_ras_pred, 32'h18);
    ret = 1; cj = 2; ajr = 32'h18; cyc("r_ret"); clr();
    chk("ras.hit", {31'b0, o_ras_miss}, 32'h0);
    ret = 1; cj = 2; ajr = 32'h18; cyc("r_emp"); clr();
    chk("ras.empty", {31'b0, o_ras_miss}, 32'h1);
    // Overflow by one: oldest lost
    for (int i = 0; i < 5; i++) begin
      pushed[i] = m_pc + 32'd8;
      link = 1; cyc("r_push"); clr();
    end
    for (int i = 0; i < 4; i++) begin
      ret = 1; ajr = pushed[4-i]; cyc("r_pop"); clr();
      chk("ras.pop", {31'b0, o_ras_miss}, 32'h0);
    end
    ret = 1; ajr = pushed[0]; cyc("r_pop5"); clr();
    chk("ras.pop5", {31'b0, o_ras_miss}, 32'h1);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      stall = (($urandom % 4) == 0);
      exc   = (($urandom % 20) == 0);
      cbr   = (($urandom % 6) == 0);
      cj    = 2'($urandom);
      aj    = 26'($urandom);
      abr   = $urandom;
      link  = (($urandom % 5) == 0);
      ret   = (($urandom % 5) == 0);
      ajr   = (($urandom % 2) == 0 && ras_q.size() != 0) ? m_pred() : $urandom;
      if (($urandom % 100) == 0) pulse_reset();
      cyc("rnd");
    end
    clr();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_pcgen.md
IF_PCGEN -- requirements
Module: if_pcgen

Interface
REQ-001 Parameter ADDR_W, default 32: PC and target width.
REQ-002 Parameter JADDR_W, default 26: jump immediate width, < ADDR_W.
REQ-003 Parameter RESET_VEC, default 0: PC value after reset.
REQ-004 Parameter EXC_VEC, default 32'h0000_0080: exception target.
REQ-005 Parameter RAS_DEPTH, default 4: return-address stack entries, power of 2, >= 2.
REQ-006 i_clk  in  1  single clock, rising edge.
REQ-007 i_rst_n  in  1  asynchronous, active-low reset.
REQ-008 i_stall  in  1  hold PC this cycle.
REQ-009 i_exc  in  1  exception redirect request.
REQ-010 i_addr_jump  in  JADDR_W  j/jal immediate target.
REQ-011 i_addr_jumpr  in  ADDR_W  jr target from rs.
REQ-012 i_addr_branch  in  ADDR_W  branch adder target.
REQ-013 i_con_jump  in  2  01 = j/jal, 10 = jr, 00/11 = none.
REQ-014 i_con_ifbranch  in  1  branch taken.
REQ-015 i_con_link  in  1  jal: push return address.
REQ-016 i_con_ret  in  1  jr $ra: pop return address.
REQ-017 o_pc  out  ADDR_W  current fetch PC.
REQ-018 o_pc_plus4  out  ADDR_W  o_pc + 4, modulo 2^ADDR_W.
REQ-019 o_pend  out  1  redirect held pending during stall.
REQ-020 o_ras_pred  out  ADDR_W  RAS top (0 when empty).
REQ-021 o_ras_miss  out  1  registered: last pop mismatched i_addr_jumpr.

Function
REQ-022 Redirect target priority: i_exc -> EXC_VEC; else i_con_ifbranch -> i_addr_branch; else jump 01 -> zero-extended i_addr_jump; else jump 10 -> i_addr_jumpr; else no redirect.
REQ-023 No stall, no redirect, no pending: PC <= o_pc_plus4 next edge (wraps all-ones+4 to 3).
REQ-024 No stall, redirect present: PC <= redirect target next edge; pending cleared.
REQ-025 No stall, no redirect, pending set: PC <= pending target; pending cleared.
REQ-026 Stall: PC holds; a present redirect is latched into pending; a later redirect overwrites pending only if of equal or higher priority under REQ-022.
REQ-027 o_pend SHALL equal the pending-valid register; latency from request to o_pc update is exactly one unstalled edge.
REQ-028 RAS (REQ-029..033) applies only with RAS_EN, on unstalled cycles.
REQ-029 i_con_link pushes o_pc_plus4 + 4 (delay-slot return address); when full, oldest entry is overwritten (circular).
REQ-030 i_con_ret pops; o_ras_miss <= (popped value != i_addr_jumpr); pop when empty sets o_ras_miss to 1 and leaves pointer unchanged.
REQ-031 Simultaneous link and ret: top replaced by new return address; count unchanged; o_ras_miss computed against old top.
REQ-032 i_exc clears o_ras_miss and does not modify RAS contents.
REQ-033 Next-PC selection SHALL never depend on RAS contents.

Reset
REQ-034 On i_rst_n low, immediately: o_pc = RESET_VEC, pending cleared, o_pend = 0, RAS count = 0, o_ras_pred = 0, o_ras_miss = 0.
REQ-035 Reset asserted mid-stall discards pending redirect; first fetch after release is RESET_VEC.

Configuration
REQ-036 Macro IF_PCGEN_RAS_EN defined: RAS logic built per REQ-029..032.
REQ-037 Macro undefined: no RAS storage; o_ras_pred = 0, o_ras_miss = 0 constantly; i_con_link/i_con_ret ignored.

Structure
REQ-038 Shared package if_pkg SHALL hold the i_con_jump encoding enum, redirect-priority enum, and default RESET_VEC/EXC_VEC constants.
REQ-039 RAS SHALL be sub-module if_ras (push, pop, top, empty, full), instantiated only under IF_PCGEN_RAS_EN.

Verification
REQ-040 Reset release, no controls, 3 edges -> o_pc 0, 4, 8, C.
REQ-041 PC = 0x100, i_con_jump=01, i_addr_jump=0x40, i_con_ifbranch=1, i_addr_branch=0x200 -> next o_pc 0x200.
REQ-042 Stall 2 cycles, jr to 0x300 in stall cycle 1, nothing in cycle 2 -> o_pend=1, o_pc held; first unstalled edge o_pc 0x300, o_pend 0.
REQ-043 Stall with pending branch 0x400, then i_exc during stall -> after release o_pc = EXC_VEC.
REQ-044 RAS_EN: jal at o_pc 0x10 pushes 0x18; later ret with i_addr_jumpr 0x18 -> o_ras_miss 0; ret with empty RAS -> o_ras_miss 1.
REQ-045 RAS_EN, depth 4: 5 pushes then 4 pops -> returns last four pushed values, fifth pop flags miss.
